// File: rtl/csa_subtractor_seq_if.sv
// Operand/result handshake bundle for csa_subtractor_seq.
// Optional flag signals (zero, ovf) exist only when CSS_FLAGS_EN is defined.
interface csa_subtractor_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef CSS_FLAGS_EN
  logic             zero;
  logic             ovf;

  modport master (output in_valid, a, b, bin, out_ready,
                  input  in_ready, out_valid, diff, bout, zero, ovf);
  modport slave  (input  in_valid, a, b, bin, out_ready,
                  output in_ready, out_valid, diff, bout, zero, ovf);
`else
  modport master (output in_valid, a, b, bin, out_ready,
                  input  in_ready, out_valid, diff, bout);
  modport slave  (input  in_valid, a, b, bin, out_ready,
                  output in_ready, out_valid, diff, bout);
`endif
endinterface

// File: rtl/csa_subtractor_seq.sv
// Multi-cycle carry-select subtractor: diff = a - b - bin, SLICES_PER_CYCLE slices per clock, LSB first.
// Define CSS_FLAGS_EN to add registered zero/ovf result flags.
module csa_subtractor_seq #(
  parameter int WIDTH            = 32,
  parameter int SLICE            = 4,
  parameter int SLICES_PER_CYCLE = 2
) (
  input logic                clk,
  input logic                rst,
  csa_subtractor_seq_if.slave bus
);

  localparam int K     = SLICE * SLICES_PER_CYCLE;
  localparam int STEPS = WIDTH / K;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, nb_q, diff_q, diff_upd;
  logic             carry_q, carry_nxt, bout_q;
  logic [SW-1:0]    step_q;
  logic [K-1:0]     win_a, win_nb, win_sum;
  logic             accept, last_step;

  // Both carry candidates are formed up front; the incoming carry only picks one.
  function automatic logic [SLICE:0] slice_sel(input logic [SLICE-1:0] x,
                                               input logic [SLICE-1:0] y,
                                               input logic             cin);
    logic [SLICE:0] s0, s1;
    s0 = {1'b0, x} + {1'b0, y};
    s1 = {1'b0, x} + {1'b0, y} + (SLICE+1)'(1);
    return cin ? s1 : s0;
  endfunction

  assign accept    = bus.in_valid && (state_q == IDLE);
  assign last_step = (step_q == SW'(STEPS - 1));

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

  always_comb begin
    logic           c;
    logic [SLICE:0] r;
    win_a   = a_q[step_q*K +: K];
    win_nb  = nb_q[step_q*K +: K];
    win_sum = '0;
    c       = carry_q;
    r       = '0;
    for (int s = 0; s < SLICES_PER_CYCLE; s++) begin
      r = slice_sel(win_a[s*SLICE +: SLICE], win_nb[s*SLICE +: SLICE], c);
      win_sum[s*SLICE +: SLICE] = r[SLICE-1:0];
      c = r[SLICE];
    end
    carry_nxt = c;
    diff_upd  = diff_q;
    diff_upd[step_q*K +: K] = win_sum;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture; a is kept true, b is stored inverted for the a + ~b + ~bin form.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= bus.a;
      nb_q <= ~bus.b;
    end
  end

`ifdef CSS_FLAGS_EN
  logic zero_q, ovf_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      step_q  <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef CSS_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else if (state_q == IDLE) begin
      if (accept) begin
        carry_q <= ~bus.bin;
        step_q  <= '0;
      end
    end else if (state_q == RUN) begin
      diff_q  <= diff_upd;
      carry_q <= carry_nxt;
      step_q  <= step_q + SW'(1);
      if (last_step) begin
        bout_q <= ~carry_nxt;
`ifdef CSS_FLAGS_EN
        zero_q <= (diff_upd == '0);
        ovf_q  <= (a_q[WIDTH-1] != ~nb_q[WIDTH-1]) && (diff_upd[WIDTH-1] != a_q[WIDTH-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_csa_subtractor_seq.sv
// Self-checking bench for csa_subtractor_seq: directed vectors plus a transaction-level reference model.
module tb_csa_subtractor_seq;

  localparam int WIDTH = 32;
  localparam int SLICE = 4;
  localparam int SPC   = 2;
  localparam int STEPS = WIDTH / (SLICE * SPC);

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  csa_subtractor_seq_if #(.WIDTH(WIDTH)) bus ();

  csa_subtractor_seq #(.WIDTH(WIDTH), .SLICE(SLICE), .SLICES_PER_CYCLE(SPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding operation, expected result computed with wide arithmetic.
  res_t        exp_q[$];
  bit          mon_en = 1'b0;
  bit          busy = 1'b0;
  bit          stream_mode = 1'b0;
  bit          have_prev = 1'b0;
  int          acc_edge = 0;
  int          prev_edge = 0;
  logic        exp_ov;
  logic [32:0] m_full;
  res_t        m_res;

  always @(negedge clk) begin
    exp_ov = busy && (cyc >= acc_edge + STEPS);
    if (mon_en) begin
      check("mon_in_ready", 64'(bus.in_ready), 64'(!busy));
      check("mon_out_valid", 64'(bus.out_valid), 64'(exp_ov));
      if (bus.out_valid && exp_q.size() > 0) begin
        check("mon_diff", 64'(bus.diff), 64'(exp_q[0].diff));
        check("mon_bout", 64'(bus.bout), 64'(exp_q[0].bout));
`ifdef CSS_FLAGS_EN
        check("mon_zero", 64'(bus.zero), 64'(exp_q[0].zero));
        check("mon_ovf", 64'(bus.ovf), 64'(exp_q[0].ovf));
`endif
      end
    end
    if (rst) begin
      busy = 1'b0;
      exp_q.delete();
    end else if (busy && exp_ov && bus.out_ready) begin
      busy = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (!busy && bus.in_valid) begin
      busy     = 1'b1;
      acc_edge = cyc + 1;
      m_full   = {1'b0, bus.a} - {1'b0, bus.b} - 33'(bus.bin);
      m_res.diff = m_full[WIDTH-1:0];
      m_res.bout = m_full[WIDTH];
      m_res.zero = (m_full[WIDTH-1:0] == '0);
      m_res.ovf  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (m_full[WIDTH-1] != bus.a[WIDTH-1]);
      exp_q.push_back(m_res);
      if (stream_mode && have_prev) check("accept_spacing", 64'(acc_edge - prev_edge), 64'(STEPS + 2));
      have_prev = stream_mode;
      prev_edge = acc_edge;
    end
  end

  task automatic wait_in_ready();
    int k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'(1));
  endtask

  task automatic wait_out_valid();
    int k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 64'(bus.out_valid), 64'(1));
  endtask

  // Called at posedge+1; returns at posedge+1 after the result has been taken.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin,
                        input logic [WIDTH-1:0] ed, input logic eb, input logic ez, input logic eo,
                        input string tag);
    bus.a = ta; bus.b = tb; bus.bin = tbin; bus.in_valid = 1'b1;
    wait_in_ready();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out_valid();
    check({tag, "_diff"}, 64'(bus.diff), 64'(ed));
    check({tag, "_bout"}, 64'(bus.bout), 64'(eb));
`ifdef CSS_FLAGS_EN
    check({tag, "_zero"}, 64'(bus.zero), 64'(ez));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
`else
    if (ez !== ez || eo !== eo) check({tag, "_flags_x"}, 64'(0), 64'(1));
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_diff", 64'(bus.diff), 64'(0));
    check("rst_bout", 64'(bus.bout), 64'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    run_op(32'd5, 32'd3, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0, "basic");
    run_op(32'd10, 32'd3, 1'b1, 32'd6, 1'b0, 1'b0, 1'b0, "borrow_in");
    run_op(32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, "full_borrow");
    run_op(32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, "signed_ovf");
    run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, "equal");
    run_op(32'd0, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, "wrap_zero");

    // Backpressure with operands toggled while the operation runs.
    bus.out_ready = 1'b0;
    bus.a = 32'hDEAD_BEEF; bus.b = 32'h0000_BEEF; bus.bin = 1'b0; bus.in_valid = 1'b1;
    wait_in_ready();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      bus.a = ~bus.a;
      bus.b = bus.b ^ 32'hFFFF_0000;
      @(posedge clk); #1;
    end
    wait_out_valid();
    repeat (3) begin
      @(negedge clk);
      check("bp_diff", 64'(bus.diff), 64'(32'hDEAD_0000));
      check("bp_bout", 64'(bus.bout), 64'(0));
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 64'(bus.out_valid), 64'(0));
    check("bp_release_in_ready", 64'(bus.in_ready), 64'(1));

    // Reset landing on the edge that would complete RUN step 2.
    bus.a = 32'd7; bus.b = 32'd2; bus.bin = 1'b0; bus.in_valid = 1'b1;
    wait_in_ready();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_diff", 64'(bus.diff), 64'(0));
    check("midrst_bout", 64'(bus.bout), 64'(0));
    run_op(32'd100, 32'd1, 1'b0, 32'd99, 1'b0, 1'b0, 1'b0, "after_rst");

    // Back-to-back stream with in_valid held high.
    stream_mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.a = $urandom; bus.b = $urandom; bus.bin = 1'($urandom_range(0, 1));
      bus.in_valid = 1'b1;
      wait_in_ready();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    stream_mode = 1'b0;
    begin
      int k = 0;
      while (exp_q.size() > 0 && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("stream_drain", 64'(exp_q.size()), 64'(0));
    end
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_subtractor_seq.md
Name: csa_subtractor_seq

Overview:
- Multi-cycle carry-select subtractor: computes diff = a - b - bin over WIDTH bits, SLICES_PER_CYCLE SLICE-bit slices per clock, LSB slice first.
- Each slice pre-computes both carry candidates (a + ~b + 0 and a + ~b + 1) and selects by the registered running carry.
- Valid/ready handshake on both sides. Sits beside the combinational carry-select adder in the ALU datapath as its inverse-operation, area-reduced counterpart.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SLICE*SLICES_PER_CYCLE.
- SLICE, 4, bits per carry-select slice.
- SLICES_PER_CYCLE, 2, slices resolved per clock.
- Derived: STEPS = WIDTH/(SLICE*SLICES_PER_CYCLE), 4 at defaults.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands offered.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when unsigned a < b + bin.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, internal carry/step counter=0.
  - rst overrides everything, including mid-RUN and in DONE; any in-flight operation is discarded with no output.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a, ~b, carry=~bin; step=0; go to RUN. in_ready drops next cycle.
- RUN:
  - in_ready=0.
  - Each cycle processes bits [step*K +: K], K = SLICE*SLICES_PER_CYCLE. Per slice: sum0/cout0 with cin=0, sum1/cout1 with cin=1; select by incoming carry; chain across the slices of the cycle.
  - Write the selected bits into the diff register; register the final carry; step++.
  - Input changes during RUN are ignored.
- After step STEPS-1 completes: go to DONE; bout = ~final_carry.
- DONE:
  - out_valid=1; diff and bout held stable.
  - On out_valid&out_ready: go to IDLE next cycle, out_valid=0.
  - No accept in the same cycle as DONE (in_ready=0 in DONE). Throughput: one op per STEPS+2 cycles.
- Latency: handshake accept at edge N gives out_valid=1 after edge N+STEPS (4 cycles at defaults).
- diff is not guaranteed meaningful while out_valid=0; partial bits may be visible. Verification checks diff only when out_valid=1.
- Arithmetic is unsigned modulo 2^WIDTH; borrow = NOT carry of a + ~b + ~bin.

Optional Feature:
- Macro: CSS_FLAGS_EN.
- Defined:
  - Adds output ports zero (1) and ovf (1), registered alongside bout, reset 0, valid when out_valid=1.
  - zero = (diff == 0).
  - ovf = signed overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the original (non-inverted) b.
  - Flags held in DONE with diff.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Basic subtraction: a=5, b=3, bin=0 accepted at edge 0 -> out_valid at edge 4, diff=2, bout=0 (zero=0, ovf=0 with flags).
- Borrow-in and full borrow: a=10, b=3, bin=1 -> diff=6, bout=0. Then a=0, b=1, bin=0 -> diff=0xFFFFFFFF, bout=1.
- Signed boundary (CSS_FLAGS_EN): a=0x80000000, b=1 -> diff=0x7FFFFFFF, bout=0, ovf=1. Then a=b=0x12345678 -> diff=0, zero=1, bout=0.
- Backpressure and ignored inputs: out_ready held 0 for 3 cycles after out_valid -> diff/bout unchanged, in_ready=0. a and b toggled during RUN -> result still reflects latched operands. Then out_ready=1 -> out_valid=0 and in_ready=1 on the next cycle.
- Mid-operation reset: rst=1 at RUN step 2 -> next cycle in_ready=1, out_valid=0, diff=0, bout=0. A new op a=100, b=1 -> diff=99 after 4 cycles.
- Back-to-back stream: 16 random operand pairs with in_valid held high and out_ready=1 -> every result matches the reference model; spacing between accepts is exactly STEPS+2 cycles.
